gf12_sram64_burst_ctrl: RTL

//  Initiator for the gf12_sram64_be_* banked SRAM wrappers: drives write port 0 (CE0/A0/D0/WE0/WEM0) and read port 1 (CE1/A1, Q1).

---
 rtl/esp_sram_ctrl_pkg.sv | 21 ++
 rtl/gf12_sram_rd_fifo.sv | 49 ++++
 rtl/gf12_sram64_burst_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/esp_sram_ctrl_pkg.sv
// Shared types for the GF12 SRAM burst controller: FSM encoding and burst request payload.
package esp_sram_ctrl_pkg;

  localparam int unsigned SRAM_ABITS     = 18;
  localparam int unsigned SRAM_DBITS     = 64;
  localparam int unsigned BURST_LEN_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } burst_state_e;

  typedef struct packed {
    logic                      is_write;
    logic [SRAM_ABITS-1:0]     addr;
    logic [BURST_LEN_BITS-1:0] len;
  } burst_req_t;

endpackage

// File: rtl/gf12_sram_rd_fifo.sv
// Read-return FIFO; head entry is presented combinationally and reads as zero when empty.
module gf12_sram_rd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  assign head   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      if (do_pop) rd_ptr <= PTR_W'(rd_ptr + 1'b1);
      case ({push, do_pop})
        2'b10:   count <= CNT_W'(count + 1'b1);
        2'b01:   count <= CNT_W'(count - 1'b1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: head is gated by empty.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/gf12_sram64_burst_ctrl.sv
// Burst initiator for the gf12_sram64_be_* wrappers: write port 0, read port 1.
// Reads return through a credit-checked FIFO because Q1 arrives one cycle after CE1 and cannot stall.
module gf12_sram64_burst_ctrl
  import esp_sram_ctrl_pkg::*;
#(
  parameter int unsigned ABITS      = 18,
  parameter int unsigned DBITS      = 64,
  parameter int unsigned LEN_BITS   = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ABITS-1:0]    req_addr,
  input  logic [LEN_BITS-1:0] req_len,
  input  logic                wdata_valid,
  output logic                wdata_ready,
  input  logic [DBITS-1:0]    wdata,
  input  logic [DBITS-1:0]    wdata_mask,
  output logic                rdata_valid,
  input  logic                rdata_ready,
  output logic [DBITS-1:0]    rdata,
  output logic                done,
  output logic                CE0,
  output logic                WE0,
  output logic [ABITS-1:0]    A0,
  output logic [DBITS-1:0]    D0,
  output logic [DBITS-1:0]    WEM0,
  output logic                CE1,
  output logic [ABITS-1:0]    A1,
  input  logic [DBITS-1:0]    Q1
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  burst_state_e        state;
  burst_req_t          req_in;
  logic [ABITS-1:0]    cur_addr;
  logic [LEN_BITS-1:0] beats_left;
  logic                inflight;
  logic [CNT_W-1:0]    fifo_count;
  logic [CNT_W-1:0]    credit_used;
  logic                fifo_empty;
  logic                wr_fire;
  logic                rd_issue;
  logic                pop;
  logic                last_beat;
  logic                drain_done;

  assign req_in = '{is_write: req_write,
                    addr:     SRAM_ABITS'(req_addr),
                    len:      BURST_LEN_BITS'(req_len)};

  // A read slot is granted only if the returning word is guaranteed a FIFO entry.
  assign credit_used = CNT_W'(fifo_count + CNT_W'(inflight));
  assign rd_issue    = (state == ST_READ) && (credit_used < CNT_W'(FIFO_DEPTH));
  assign wr_fire     = (state == ST_WRITE) && wdata_valid;
  assign last_beat   = (beats_left == '0);

  assign rdata_valid = !fifo_empty;
  assign pop         = rdata_valid && rdata_ready;
  assign drain_done  = !inflight &&
                       ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop));

  // Memory-side strobes follow the beat handshake in the same cycle; idle buses read as zero.
  assign CE0  = wr_fire;
  assign WE0  = wr_fire;
  assign A0   = wr_fire ? cur_addr   : '0;
  assign D0   = wr_fire ? wdata      : '0;
  assign WEM0 = wr_fire ? wdata_mask : '0;
  assign CE1  = rd_issue;
  assign A1   = rd_issue ? cur_addr  : '0;

  gf12_sram_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DBITS)
  ) u_rd_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (inflight),
    .push_data (Q1),
    .pop       (pop),
    .head      (rdata),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= ST_IDLE;
      cur_addr    <= '0;
      beats_left  <= '0;
      inflight    <= 1'b0;
      req_ready   <= 1'b1;
      wdata_ready <= 1'b0;
      done        <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= rd_issue;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            cur_addr    <= ABITS'(req_in.addr);
            beats_left  <= LEN_BITS'(req_in.len);
            req_ready   <= 1'b0;
            wdata_ready <= req_in.is_write;
            state       <= req_in.is_write ? ST_WRITE : ST_READ;
          end
        end
        ST_WRITE: begin
          if (wr_fire) begin
            cur_addr   <= ABITS'(cur_addr + 1'b1);
            beats_left <= LEN_BITS'(beats_left - 1'b1);
            if (last_beat) begin
              state       <= ST_IDLE;
              done        <= 1'b1;
              req_ready   <= 1'b1;
              wdata_ready <= 1'b0;
            end
          end
        end
        ST_READ: begin
          if (rd_issue) begin
            cur_addr   <= ABITS'(cur_addr + 1'b1);
            beats_left <= LEN_BITS'(beats_left - 1'b1);
            if (last_beat) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Leave once the final word has been consumed; done lands the cycle after that pop.
          if (drain_done) begin
            state     <= ST_IDLE;
            done      <= 1'b1;
            req_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
